// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, limits and helpers for the pipeline hazard controller.
// Holds the default register-address width, the load scoreboard entry type,
// the maximum supported load latency and the mul/div counter width helper.
package hazard_pkg;

    // Default register address width (32 architectural registers).
    localparam int RW_DEF = 5;

    // Widest register address a scoreboard entry can hold; narrower
    // addresses are zero-extended into it.
    localparam int RW_MAX = 8;

    // Deepest load latency the scoreboard supports.
    localparam int MAX_LOAD_LAT = 4;

    // One in-flight load: whether the slot holds a real load and its target.
    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] rd;
    } sb_entry_t;

    // Width of a down-counter that must hold the value md_lat.
    function automatic int md_cnt_width(input int md_lat);
        return $clog2(md_lat + 1);
    endfunction

    // True when register r is a live source of the instruction in ID.
    // Register 0 is hardwired to zero and never creates a dependency.
    function automatic logic src_hit(
        input logic [RW_MAX-1:0] r,
        input logic [RW_MAX-1:0] rs,
        input logic [RW_MAX-1:0] rt,
        input logic              use_rs,
        input logic              use_rt
    );
        return (r != '0) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
    endfunction

endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: shift register of loads that have left EX but whose data
// is not yet forwardable, plus the match against the ID source registers.
// A load enters stage 0 on the edge it leaves EX and falls off the end after
// DEPTH further advancing edges. The whole register freezes on mem_stall so
// the remaining wait of each load is preserved across a memory stall.
module load_scoreboard
    import hazard_pkg::*;
#(
    parameter int RW    = RW_DEF,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_mem_stall,
    input  logic          i_ex_mem_read,
    input  logic [RW-1:0] i_ex_rt,
    input  logic [RW-1:0] i_id_rs,
    input  logic [RW-1:0] i_id_rt,
    input  logic          i_id_uses_rs,
    input  logic          i_id_uses_rt,
    output logic          o_sb
);

    sb_entry_t r_stage [DEPTH];
    sb_entry_t w_new;
    logic      w_sb;

    // Entry for the instruction currently leaving EX; loads to $0 are dropped.
    always_comb begin
        w_new       = '0;
        w_new.valid = i_ex_mem_read && (i_ex_rt != '0);
        w_new.rd    = RW_MAX'(i_ex_rt);
    end

    // Advance the scoreboard one stage per unstalled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (!i_mem_stall) begin
            r_stage[0] <= w_new;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Any valid pending load whose target the ID instruction reads.
    always_comb begin
        w_sb = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_stage[i].valid &&
                src_hit(r_stage[i].rd, RW_MAX'(i_id_rs), RW_MAX'(i_id_rt),
                        i_id_uses_rs, i_id_uses_rt)) begin
                w_sb = 1'b1;
            end
        end
    end

    assign o_sb = w_sb;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the 5-stage pipeline, sitting beside ID.
// Combines load-use (EX load plus a LOAD_LAT-deep scoreboard), mul/div HI/LO
// busy tracking and branch flush policy (0 or 1 delay slot) into the IF/ID and
// ID/EX enables and flushes; a data-memory stall freezes everything.
// Optional build macro HAZARD_PERF_CNT_EN adds ld_stall_cnt, md_stall_cnt and
// flush_cnt performance counters; without it those ports do not exist.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RW          = RW_DEF,
    parameter int LOAD_LAT    = 0,
    parameter int MD_LAT      = 4,
    parameter int DELAY_SLOTS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_stall,
    input  logic          ex_mem_read,
    input  logic [RW-1:0] ex_rt,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic          ex_branch_taken,
    input  logic          ex_md_start,
    input  logic          id_md_op,
    output logic          stall_if,
    output logic          stall_id,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic          md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]   ld_stall_cnt,
    output logic [31:0]   md_stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    localparam int MD_CW = md_cnt_width(MD_LAT);

    // Reject configurations the control equations are not written for.
    if ((DELAY_SLOTS != 0) && (DELAY_SLOTS != 1)) begin : g_bad_delay_slots
        $error("hazard_ctrl: DELAY_SLOTS must be 0 or 1");
    end
    if ((LOAD_LAT < 0) || (LOAD_LAT > MAX_LOAD_LAT)) begin : g_bad_load_lat
        $error("hazard_ctrl: LOAD_LAT out of range 0..4");
    end
    if (MD_LAT < 1) begin : g_bad_md_lat
        $error("hazard_ctrl: MD_LAT must be at least 1");
    end
    if ((RW < 1) || (RW > RW_MAX)) begin : g_bad_rw
        $error("hazard_ctrl: RW out of range");
    end

    logic [MD_CW-1:0] r_md_cnt;
    logic [MD_CW-1:0] w_md_cnt_nxt;
    logic             r_md_busy;

    logic w_lu;
    logic w_sb;
    logic w_mdh;
    logic w_ld_hz;
    logic w_hz;

    // Load in EX whose target the ID instruction needs: classic load-use bubble.
    assign w_lu = ex_mem_read &&
                  src_hit(RW_MAX'(ex_rt), RW_MAX'(id_rs), RW_MAX'(id_rt),
                          id_uses_rs, id_uses_rt);

    // Loads already past EX are only tracked when memory has extra latency.
    if (LOAD_LAT > 0) begin : g_sb
        load_scoreboard #(
            .RW    (RW),
            .DEPTH (LOAD_LAT)
        ) u_load_scoreboard (
            .clk           (clk),
            .rst           (rst),
            .i_mem_stall   (mem_stall),
            .i_ex_mem_read (ex_mem_read),
            .i_ex_rt       (ex_rt),
            .i_id_rs       (id_rs),
            .i_id_rt       (id_rt),
            .i_id_uses_rs  (id_uses_rs),
            .i_id_uses_rt  (id_uses_rt),
            .o_sb          (w_sb)
        );
    end else begin : g_no_sb
        assign w_sb = 1'b0;
    end

    assign w_mdh   = id_md_op && r_md_busy;
    assign w_ld_hz = w_lu || w_sb;
    assign w_hz    = w_ld_hz || w_mdh;

    // Next mul/div occupancy: reload on issue, otherwise count down to zero.
    always_comb begin
        w_md_cnt_nxt = r_md_cnt;
        if (ex_md_start) begin
            w_md_cnt_nxt = MD_CW'(MD_LAT);
        end else if (r_md_cnt != '0) begin
            w_md_cnt_nxt = r_md_cnt - 1'b1;
        end
    end

    // Mul/div counter and its registered busy flag; runs through memory stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_md_cnt  <= '0;
            r_md_busy <= 1'b0;
        end else begin
            r_md_cnt  <= w_md_cnt_nxt;
            r_md_busy <= (w_md_cnt_nxt != '0);
        end
    end

    assign md_busy = r_md_busy;

    // Prioritised stall/flush decode: memory stall, then taken branch, then hazards.
    // Outputs are forced low while reset is asserted so nothing leaks from
    // inputs that are still presenting a hazard.
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst) begin
            stall_if = 1'b0;
        end else if (mem_stall) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else if (ex_branch_taken) begin
            if (DELAY_SLOTS == 0) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (!w_hz) begin
                flush_if_id = 1'b1;
            end else begin
                // Hold the delay slot in IF/ID; the wrong-path fetch is never
                // latched because IF/ID is not written this cycle.
                stall_if    = 1'b1;
                stall_id    = 1'b1;
                flush_id_ex = 1'b1;
            end
        end else if (w_hz) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_ld_stall_cnt;
    logic [31:0] r_md_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Wrapping event counters; a frozen pipe does not accumulate events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_stall_cnt <= '0;
            r_md_stall_cnt <= '0;
            r_flush_cnt    <= '0;
        end else if (!mem_stall) begin
            if (w_ld_hz && stall_id) begin
                r_ld_stall_cnt <= r_ld_stall_cnt + 32'd1;
            end
            if (w_mdh && !w_ld_hz && stall_id) begin
                r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
            end
            if (flush_if_id || flush_id_ex) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign ld_stall_cnt = r_ld_stall_cnt;
    assign md_stall_cnt = r_md_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
`else
    localparam bit PERF_CNT_PRESENT = 1'b0;
`endif

`ifndef SYNTHESIS
    // A new mul/div must not issue while HI/LO is still occupied.
    a_md_start_idle: assert property (@(posedge clk) disable iff (rst)
        !(ex_md_start && r_md_busy));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Three instances share one stimulus stream:
// d0 (LOAD_LAT=0, 1 delay slot), d2 (LOAD_LAT=2, 1 delay slot) and
// dz (LOAD_LAT=0, no delay slot). Each cycle's inputs are applied just after
// the rising edge and the combinational outputs are checked before the next.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_stall;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_branch_taken;
    logic       ex_md_start;
    logic       id_md_op;

    logic si0, sd0, fi0, fe0, mb0;
    logic si2, sd2, fi2, fe2, mb2;
    logic siz, sdz, fiz, fez, mbz;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RW(5), .LOAD_LAT(0), .MD_LAT(4), .DELAY_SLOTS(1)) d0 (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
        .ex_md_start(ex_md_start), .id_md_op(id_md_op),
        .stall_if(si0), .stall_id(sd0), .flush_if_id(fi0), .flush_id_ex(fe0),
        .md_busy(mb0));

    hazard_ctrl #(.RW(5), .LOAD_LAT(2), .MD_LAT(4), .DELAY_SLOTS(1)) d2 (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
        .ex_md_start(ex_md_start), .id_md_op(id_md_op),
        .stall_if(si2), .stall_id(sd2), .flush_if_id(fi2), .flush_id_ex(fe2),
        .md_busy(mb2));

    hazard_ctrl #(.RW(5), .LOAD_LAT(0), .MD_LAT(4), .DELAY_SLOTS(0)) dz (
        .clk(clk), .rst(rst), .mem_stall(mem_stall), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
        .ex_md_start(ex_md_start), .id_md_op(id_md_op),
        .stall_if(siz), .stall_id(sdz), .flush_if_id(fiz), .flush_id_ex(fez),
        .md_busy(mbz));

    // Output vectors ordered {stall_if, stall_id, flush_if_id, flush_id_ex}.
    wire [3:0] v0 = {si0, sd0, fi0, fe0};
    wire [3:0] v2 = {si2, sd2, fi2, fe2};
    wire [3:0] vz = {siz, sdz, fiz, fez};

    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] HZ    = 4'b1101;
    localparam logic [3:0] FRZ   = 4'b1100;
    localparam logic [3:0] BR1   = 4'b0010;
    localparam logic [3:0] BR0   = 4'b0011;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs, then let the combinational outputs settle.
    task automatic apply(input logic mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt,
                         input logic br, input logic mds, input logic mdo,
                         input logic ms);
        ex_mem_read     = mr;
        ex_rt           = ert;
        id_rs           = rs;
        id_uses_rs      = urs;
        id_rt           = rt;
        id_uses_rt      = urt;
        ex_branch_taken = br;
        ex_md_start     = mds;
        id_md_op        = mdo;
        mem_stall       = ms;
        #2;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        chk("reset_d0", v0, NONE);
        chk("reset_d2", v2, NONE);
        chk("reset_dz", vz, NONE);
        chk("reset_md_busy", {3'b0, mb2}, 4'b0000);
        nxt();
        rst = 1'b0;

        // lw $5 in EX, add $6,$5,$1 in ID.
        apply(1, 5, 5, 1, 1, 1, 0, 0, 0, 0);
        chk("lu_ll0_c1", v0, HZ);
        chk("lu_ll2_c1", v2, HZ);
        nxt();
        apply(0, 0, 5, 1, 1, 1, 0, 0, 0, 0);
        chk("lu_ll0_c2", v0, NONE);
        chk("lu_ll2_c2", v2, HZ);
        nxt();
        apply(0, 0, 5, 1, 1, 1, 0, 0, 0, 0);
        chk("lu_ll2_c3", v2, HZ);
        nxt();
        apply(0, 0, 5, 1, 1, 1, 0, 0, 0, 0);
        chk("lu_ll2_c4", v2, NONE);
        nxt();

        // Load to $0 with a reader of $0: never a hazard.
        apply(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("zero_reg_d0", v0, NONE);
        chk("zero_reg_d2", v2, NONE);
        nxt();
        idle();
        chk("zero_reg_sb", v2, NONE);
        nxt();

        // lw $7, two independent instructions, then a reader of $7 (LOAD_LAT=2).
        apply(1, 7, 2, 1, 3, 1, 0, 0, 0, 0);
        chk("dist3_a", v2, NONE);
        nxt();
        apply(0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        chk("dist3_b", v2, NONE);
        nxt();
        apply(0, 0, 1, 1, 7, 1, 0, 0, 0, 0);
        chk("dist3_c_ll2", v2, HZ);
        chk("dist3_c_ll0", v0, NONE);
        nxt();
        apply(0, 0, 1, 1, 7, 1, 0, 0, 0, 0);
        chk("dist3_d", v2, NONE);
        nxt();

        // mult issues from EX, mflo waits in ID for four cycles.
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("md_start_busy", {3'b0, mb2}, 4'b0000);
        chk("md_start_out", v2, NONE);
        nxt();
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("md_busy_%0d", i), {3'b0, mb2}, 4'b0001);
            chk($sformatf("md_stall_%0d", i), v2, HZ);
            nxt();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("md_done_busy", {3'b0, mb2}, 4'b0000);
        chk("md_done_out", v2, NONE);
        nxt();

        // Taken branch with an independent delay slot.
        apply(0, 0, 3, 1, 4, 1, 1, 0, 0, 0);
        chk("br_ds1", v0, BR1);
        chk("br_ds0", vz, BR0);
        nxt();

        // Taken branch whose delay slot waits on HI/LO.
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        nxt();
        apply(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("br_hz_ds1", v0, HZ);
        chk("br_hz_ds0", vz, BR0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            idle();
            nxt();
        end
        idle();
        chk("br_md_drained", {3'b0, mb0}, 4'b0000);
        nxt();

        // Memory stall freezes a pending load; remaining stall resumes after.
        apply(1, 9, 9, 1, 0, 0, 0, 0, 0, 0);
        chk("ms_lu", v2, HZ);
        nxt();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 9, 1, 0, 0, 0, 0, 0, 1);
            chk($sformatf("ms_frozen_d2_%0d", i), v2, FRZ);
            chk($sformatf("ms_frozen_d0_%0d", i), v0, FRZ);
            nxt();
        end
        apply(0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        chk("ms_resume_1", v2, HZ);
        nxt();
        apply(0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        chk("ms_resume_2", v2, HZ);
        nxt();
        apply(0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        chk("ms_resume_end", v2, NONE);
        nxt();

        // Reset while a load is pending and the mul/div is busy.
        apply(1, 7, 7, 1, 0, 0, 0, 1, 0, 0);
        chk("rst_pre_lu", v2, HZ);
        nxt();
        apply(0, 0, 7, 1, 0, 0, 0, 0, 1, 0);
        chk("rst_pre_out", v2, HZ);
        chk("rst_pre_busy", {3'b0, mb2}, 4'b0001);
        rst = 1'b1;
        #1;
        chk("rst_mid_out", v2, NONE);
        chk("rst_mid_busy", {3'b0, mb2}, 4'b0000);
        nxt();
        rst = 1'b0;
        #2;
        chk("rst_post_out", v2, NONE);
        chk("rst_post_busy", {3'b0, mb2}, 4'b0000);
        nxt();
        apply(0, 0, 7, 1, 0, 0, 0, 0, 1, 0);
        chk("rst_post_out2", v2, NONE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS-style core.
- Generalises the single-cycle load-use check in four ways:
  - configurable memory load latency, tracked by a load scoreboard shift register;
  - multi-cycle multiply/divide busy tracking;
  - branch flush policy selected by delay-slot count;
  - global freeze on memory stall.
- Sits beside the ID stage. Drives the IF/ID and ID/EX pipeline-register enables and flushes.

Parameters:
- RW, 5, register address width.
- LOAD_LAT, 0, extra cycles after MEM before load data can be forwarded (0 = classic single-bubble load-use). Legal range 0..4.
- MD_LAT, 4, cycles a mul/div occupies HI/LO after issue from EX (≥1).
- DELAY_SLOTS, 1, branch delay slots (0 or 1; other values illegal, elaboration error).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_stall  in  1  data-memory stall; freezes the pipe
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  RW  EX load destination
- id_rs  in  RW  ID source register 1
- id_rt  in  RW  ID source register 2
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_md_start  in  1  mul/div issuing from EX this cycle
- id_md_op  in  1  ID instruction reads HI/LO or starts mul/div
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- flush_if_id  out  1  load bubble into IF/ID
- flush_id_ex  out  1  load bubble into ID/EX
- md_busy  out  1  mul/div in flight

Behaviour:
- Reset: all outputs 0, scoreboard invalid, md counter 0. Reset mid-operation discards pending loads and the in-flight mul/div.
- src_hit(r): r≠0 and ((id_uses_rs && r==id_rs) || (id_uses_rt && r==id_rt)).
- Load hazard:
  - lu = ex_mem_read && src_hit(ex_rt);
  - sb = any valid scoreboard stage i (0..LOAD_LAT−1) with src_hit(stage[i].rd).
- Scoreboard:
  - LOAD_LAT-deep shift register of {valid, rd}.
  - On each edge with !mem_stall: stage[0] ← {ex_mem_read && ex_rt≠0, ex_rt}; stage[i] ← stage[i−1].
  - Holds when mem_stall is high. Absent (no flops) when LOAD_LAT=0.
- Mul/div counter:
  - ex_md_start loads MD_LAT; otherwise the counter decrements when nonzero.
  - Runs independent of mem_stall.
  - md_busy = counter≠0 (registered).
  - mdh = id_md_op && md_busy.
  - ex_md_start while busy reloads MD_LAT; this is a protocol violation and is asserted in simulation.
- hz = lu | sb | mdh.
- Priority 1, mem_stall: stall_if = stall_id = 1; both flushes 0.
- Priority 2, ex_branch_taken:
  - DELAY_SLOTS=0: flush_if_id = 1, flush_id_ex = 1, stalls 0.
  - DELAY_SLOTS=1: the delay-slot instruction in ID proceeds.
    - If !hz: flush_if_id = 1, flush_id_ex = 0.
    - If hz: stall_if = stall_id = 1, flush_id_ex = 1, flush_if_id = 0. IF/ID keeps the slot; the wrong-path fetch is never latched.
  - PC redirect on taken overrides stall_if in PC logic.
- Priority 3, hz: stall_if = stall_id = 1, flush_id_ex = 1.
- Stall lengths:
  - dependent use directly after a load stalls LOAD_LAT+1 cycles;
  - md stall lasts until the counter reaches 0.
- Outputs other than md_busy are combinational from inputs and state; zero latency.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs ld_stall_cnt[31:0], md_stall_cnt[31:0], flush_cnt[31:0].
  - Each is a wrapping saturation-free counter, reset 0.
  - Increments per cycle of (lu|sb) stall, mdh-only stall, and any flush respectively.
  - Counting is suppressed while mem_stall is high.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- hazard_pkg holds:
  - RW default;
  - a scoreboard entry typedef {valid, rd};
  - MAX_LOAD_LAT = 4;
  - the md counter width function clog2(MD_LAT+1).
- Sub-module load_scoreboard: shift register plus match logic, outputs sb. Instantiated only when LOAD_LAT>0.

Test Plan:
- LOAD_LAT=0: lw $5 then add $6,$5,$1 → exactly 1 cycle stall_if/stall_id/flush_id_ex; none if the source is $0.
- LOAD_LAT=2: lw $7 then dependent use → 3-cycle stall. Use placed 2 instructions after the load → 1-cycle stall.
- MD_LAT=4: ex_md_start, then mflo in ID the next cycle → md_busy 4 cycles, stall until the counter reaches 0; mflo reaches EX on cycle 5.
- DELAY_SLOTS=1, taken branch with an independent slot → flush_if_id=1, flush_id_ex=0. DELAY_SLOTS=0 → both flushes 1.
- mem_stall=1 for 3 cycles with a load in the scoreboard → stalls held, no flushes, scoreboard frozen; the dependent stall resumes with its remaining count.
- Assert rst mid-stall (LOAD_LAT=2, md busy) → all outputs 0 immediately, md_busy 0, no residual stall after release.
